// File: rtl/cmos_chk_pkg.sv
// Shared types and constants for the CMOS gate-bank checker.
// Gate indices follow the bit order of the bank's dut_out bus.
package cmos_chk_pkg;

   typedef enum logic [2:0] {
      IDLE,
      APPLY,
      SETTLE,
      CHECK,
      DONE
   } state_t;

   localparam int GI_INV    = 0;
   localparam int GI_NAND   = 1;
   localparam int GI_NOR    = 2;
   localparam int GI_XOR    = 3;
   localparam int GI_XNOR   = 4;
   localparam int GI_AND    = 5;
   localparam int GI_OR     = 6;
   localparam int NUM_GATES = 7;

   // Feedback taps at bits 15, 13, 12 and 10.
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      return {l[14:0], ^(l & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/cmos_chk_golden.sv
// Combinational golden model of the 7-gate bank.
// Multi-input gates reduce across the whole stimulus vector.
module cmos_chk_golden
   import cmos_chk_pkg::*;
#(
   parameter int N_IN = 2
) (
   input  logic [N_IN-1:0]      i_stim,
   output logic [NUM_GATES-1:0] o_expected
);

   always_comb begin
      // NOTE: assign a default first so no path through the block leaves the output unassigned (no latch).
      o_expected           = '0;
      o_expected[GI_INV]   = ~i_stim[0];
      o_expected[GI_NAND]  = ~(&i_stim);
      o_expected[GI_NOR]   = ~(|i_stim);
      o_expected[GI_XOR]   = ^i_stim;
      o_expected[GI_XNOR]  = ~(^i_stim);
      o_expected[GI_AND]   = &i_stim;
      o_expected[GI_OR]    = |i_stim;
   end

endmodule

// File: rtl/cmos_gate_checker.sv
// Stimulus/check engine: walks exhaustive or LFSR vectors through the gate bank,
// waits the settle time, and records error count plus the first failing vector.
module cmos_gate_checker
   import cmos_chk_pkg::*;
#(
   parameter int          N_IN          = 2,
   parameter int          SETTLE_CYCLES = 4,
   parameter int          NUM_VECTORS   = 16,
   parameter int          ERR_W         = 8,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 abort,
   input  logic                 mode,
   output logic [N_IN-1:0]      stim,
   input  logic [NUM_GATES-1:0] dut_out,
   output logic                 busy,
   output logic                 done,
   output logic [ERR_W-1:0]     err_count,
   output logic                 err_sat,
   output logic [N_IN-1:0]      fail_vec,
   output logic [NUM_GATES-1:0] fail_mask,
   output logic                 fail_valid
);

   localparam logic [15:0] SEED        = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
   localparam int          EXH_VECTORS = 1 << N_IN;
   localparam int          MAX_VECTORS = (EXH_VECTORS > NUM_VECTORS) ? EXH_VECTORS : NUM_VECTORS;
   localparam int          IDX_W       = $clog2(MAX_VECTORS + 1);
   localparam int          SET_W       = $clog2(SETTLE_CYCLES + 1);
   localparam logic [IDX_W-1:0] LAST_EXH = IDX_W'(EXH_VECTORS - 1);
   localparam logic [IDX_W-1:0] LAST_RND = IDX_W'(NUM_VECTORS - 1);
   localparam logic [SET_W-1:0] LAST_SET = SET_W'(SETTLE_CYCLES - 1);

   state_t                 r_state;
   state_t                 w_next;
   logic                   r_mode;
   logic [IDX_W-1:0]       r_idx;
   logic [SET_W-1:0]       r_set_cnt;
   logic [15:0]            r_lfsr;
   logic [ERR_W-1:0]       r_err;
   logic                   r_sat;
   logic [N_IN-1:0]        r_fvec;
   logic [NUM_GATES-1:0]   r_fmask;
   logic                   r_fvalid;

   logic [N_IN-1:0]        w_stim;
   logic [NUM_GATES-1:0]   w_exp;
   logic [NUM_GATES-1:0]   w_mism;
   logic                   w_last;
   logic                   w_settled;

   assign w_stim    = r_mode ? r_lfsr[N_IN-1:0] : r_idx[N_IN-1:0];
   assign w_last    = (r_idx == (r_mode ? LAST_RND : LAST_EXH));
   assign w_settled = (r_set_cnt == LAST_SET);

   cmos_chk_golden #(.N_IN(N_IN)) u_golden (
      .i_stim     (w_stim),
      .o_expected (w_exp)
   );

   // Case inequality so an X/Z from the bank counts as a mismatch; synthesis sees a plain compare.
   always_comb begin
      w_mism = '0;
      for (int g = 0; g < NUM_GATES; g++) begin
         w_mism[g] = (dut_out[g] !== w_exp[g]);
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    if (start) w_next = APPLY;
         APPLY:   w_next = SETTLE;
         SETTLE:  if (w_settled) w_next = CHECK;
         CHECK:   w_next = w_last ? DONE : APPLY;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
      if (abort && (r_state != IDLE)) begin
         w_next = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         r_state <= w_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mode    <= 1'b0;
         r_idx     <= '0;
         r_set_cnt <= '0;
         r_lfsr    <= SEED;
         r_err     <= '0;
         r_sat     <= 1'b0;
         r_fvec    <= '0;
         r_fmask   <= '0;
         r_fvalid  <= 1'b0;
      end else begin
         if ((r_state == IDLE) && start) begin
            r_mode   <= mode;
            r_idx    <= '0;
            r_lfsr   <= SEED;
            r_err    <= '0;
            r_sat    <= 1'b0;
            r_fvalid <= 1'b0;
         end

         if (r_state == SETTLE) begin
            r_set_cnt <= r_set_cnt + 1'b1;
         end else begin
            r_set_cnt <= '0;
         end

         if (r_state == CHECK) begin
            r_idx  <= r_idx + 1'b1;
            r_lfsr <= lfsr_step(r_lfsr);
            if (|w_mism) begin
               if (&r_err) begin
                  r_sat <= 1'b1;
               end else begin
                  r_err <= r_err + 1'b1;
               end
               if (!r_fvalid) begin
                  r_fvalid <= 1'b1;
                  r_fvec   <= w_stim;
                  r_fmask  <= w_mism;
               end
            end
         end
      end
   end

   assign stim       = w_stim;
   assign busy       = (r_state == APPLY) || (r_state == SETTLE) || (r_state == CHECK);
   assign done       = (r_state == DONE);
   assign err_count  = r_err;
   assign err_sat    = r_sat;
   assign fail_vec   = r_fvec;
   assign fail_mask  = r_fmask;
   assign fail_valid = r_fvalid;

endmodule
